// File: rtl/home_pos_ctrl_pkg.sv
// Shared definitions for the homing/position controller: state codes,
// count width and the per-state drive pattern toward the supervisor.
package home_pos_ctrl_pkg;

  localparam int COUNT_W = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEEK    = 3'd1;
  localparam logic [2:0] ST_BACKOFF = 3'd2;
  localparam logic [2:0] ST_ZERO    = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SEEK    = ST_SEEK,
    S_BACKOFF = ST_BACKOFF,
    S_ZERO    = ST_ZERO,
    S_RUN     = ST_RUN,
    S_FAULT   = ST_FAULT
  } state_t;

  // away = 1 means mtr_dir is the opposite of homing_dir
  typedef struct packed {
    logic en;
    logic take;
    logic away;
  } drive_t;

  function automatic drive_t drive_for(state_t s, logic cmd_en, logic cmd_away);
    drive_t d;
    d = '0;
    case (s)
      S_SEEK:    d = '{en: 1'b1,   take: 1'b1, away: 1'b0};
      S_BACKOFF: d = '{en: 1'b1,   take: 1'b1, away: 1'b1};
      S_ZERO:    d = '{en: 1'b0,   take: 1'b1, away: 1'b1};
      S_RUN:     d = '{en: cmd_en, take: 1'b0, away: cmd_away};
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/home_pos_ctrl_debounce.sv
// Two-flop synchroniser followed by a stability counter; dout follows din
// only after DEBOUNCE_CYC consecutive cycles of the new synchronised value.
module sensor_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      // NOTE: non-blocking keeps the two synchroniser stages as separate flops.
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        cnt  <= '0;
        dout <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/home_pos_ctrl.sv
// Rail position tracker and homing sequencer feeding the end-stop supervisor:
// seek the sensor, back off, zero the count, then hand the axis to RUN.
module home_pos_ctrl
  import home_pos_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1000,
  parameter int BACKOFF_STEPS  = 200,
  parameter int SEEK_MAX_STEPS = 2000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_home,
  input  logic               homing_dir,
  input  logic               sensor_raw,
  input  logic               step_in,
  input  logic               cmd_dir,
  input  logic               cmd_en,
  input  logic               sup_error,
  output logic [COUNT_W-1:0] motor_count,
  output logic               mtr_dir,
  output logic               en_out,
  output logic               take_ctrl,
  output logic               sensor_f,
  output logic               homed,
  output logic               home_fault,
  output logic [2:0]         state
);

  localparam int STEP_MAX = (SEEK_MAX_STEPS > BACKOFF_STEPS) ? SEEK_MAX_STEPS : BACKOFF_STEPS;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);

  state_t            st, st_nx;
  drive_t            drv_nx;
  logic              step_q, step_evt, away_q, toward, counting;
  logic              seek_done, back_done;
  logic [STEP_W-1:0] step_cnt;

  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sensor_raw),
    .dout (sensor_f)
  );

  // Direction is stored relative to homing_dir so reset lands on homing_dir.
  assign mtr_dir   = homing_dir ^ away_q;
  assign toward    = (mtr_dir == homing_dir);
  assign step_evt  = step_in & ~step_q;
  assign counting  = (st == S_SEEK) || (st == S_BACKOFF) || (st == S_RUN);
  assign seek_done = step_evt && (step_cnt == STEP_W'(SEEK_MAX_STEPS - 1));
  assign back_done = step_evt && (step_cnt == STEP_W'(BACKOFF_STEPS - 1));
  assign state     = st;

  always_comb begin
    // NOTE: default first so every path assigns st_nx and no latch is inferred.
    st_nx = st;
    case (st)
      S_IDLE:    if (start_home) st_nx = S_SEEK;
      S_SEEK: begin
        if (sup_error)     st_nx = S_FAULT;
        else if (sensor_f) st_nx = S_BACKOFF;
        else if (seek_done) st_nx = S_FAULT;
      end
      S_BACKOFF: begin
        if (sup_error)      st_nx = S_FAULT;
        else if (back_done) st_nx = sensor_f ? S_FAULT : S_ZERO;
      end
      S_ZERO:    st_nx = S_RUN;
      S_RUN:     if (start_home) st_nx = S_SEEK;
      S_FAULT:   if (start_home) st_nx = S_SEEK;
      default:   st_nx = S_IDLE;
    endcase
    drv_nx = drive_for(st_nx, cmd_en, cmd_dir ^ homing_dir);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      en_out      <= 1'b0;
      take_ctrl   <= 1'b0;
      away_q      <= 1'b0;
      step_q      <= 1'b0;
      step_cnt    <= '0;
      motor_count <= '0;
      homed       <= 1'b0;
      home_fault  <= 1'b0;
    end else begin
      st                           <= st_nx;
      {en_out, take_ctrl, away_q}  <= drv_nx;
      step_q                       <= step_in;
      homed                        <= (st_nx == S_RUN);
      home_fault                   <= (st_nx == S_FAULT);

      if (st_nx != st)
        step_cnt <= '0;
      else if (step_evt && (st == S_SEEK || st == S_BACKOFF))
        step_cnt <= step_cnt + 1'b1;

      // A step landing on the ZERO cycle is dropped by the clear.
      if (st == S_ZERO) begin
        motor_count <= '0;
      end else if (step_evt && counting) begin
        if (toward) begin
          if (motor_count != '0) motor_count <= motor_count - 1'b1;
        end else begin
          if (motor_count != '1) motor_count <= motor_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_home_pos_ctrl.sv
// Directed bench for home_pos_ctrl with short debounce/backoff/seek limits
// so every homing path, saturation and error case fits in a few hundred cycles.
module tb_home_pos_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start_home, homing_dir, sensor_raw, step_in;
  logic        cmd_dir, cmd_en, sup_error;
  logic [31:0] motor_count;
  logic        mtr_dir, en_out, take_ctrl, sensor_f, homed, home_fault;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  home_pos_ctrl #(
    .DEBOUNCE_CYC  (4),
    .BACKOFF_STEPS (5),
    .SEEK_MAX_STEPS(50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_home (start_home),
    .homing_dir (homing_dir),
    .sensor_raw (sensor_raw),
    .step_in    (step_in),
    .cmd_dir    (cmd_dir),
    .cmd_en     (cmd_en),
    .sup_error  (sup_error),
    .motor_count(motor_count),
    .mtr_dir    (mtr_dir),
    .en_out     (en_out),
    .take_ctrl  (take_ctrl),
    .sensor_f   (sensor_f),
    .homed      (homed),
    .home_fault (home_fault),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      step_in = 1'b1;
      tick();
      step_in = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_start();
    start_home = 1'b1;
    tick();
    start_home = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_home = 1'b0; homing_dir = 1'b0; sensor_raw = 1'b0;
    step_in = 1'b0; cmd_dir = 1'b0; cmd_en = 1'b0; sup_error = 1'b0;

    // Reset held with step_in toggling
    for (int i = 0; i < 6; i++) begin
      step_in = ~step_in;
      tick();
    end
    step_in = 1'b0;
    check("rst count", motor_count, 32'd0);
    check("rst en", en_out, 0);
    check("rst state", state, 0);
    check("rst homed", homed, 0);
    check("rst dir", mtr_dir, homing_dir);
    check("rst sensor_f", sensor_f, 0);
    rst_n = 1'b1;
    tick(3);
    check("idle after rst", state, 0);

    // Normal homing
    pulse_start();
    check("seek state", state, 1);
    check("seek en", en_out, 1);
    check("seek take", take_ctrl, 1);
    check("seek dir", mtr_dir, 0);

    // 3-cycle glitch is rejected
    sensor_raw = 1'b1;
    tick(3);
    sensor_raw = 1'b0;
    tick(8);
    check("glitch sensor_f", sensor_f, 0);
    check("glitch state", state, 1);

    step(10);
    check("seek count sat0", motor_count, 32'd0);
    check("seek still", state, 1);

    sensor_raw = 1'b1;
    tick(5);
    check("sensor_f lat-1", sensor_f, 0);
    tick();
    check("sensor_f lat", sensor_f, 1);
    tick();
    check("backoff state", state, 2);
    check("backoff dir", mtr_dir, 1);
    check("backoff en", en_out, 1);

    step(2);
    check("backoff count2", motor_count, 32'd2);
    sensor_raw = 1'b0;
    tick(7);
    check("sensor_f fall", sensor_f, 0);
    step(2);
    check("backoff count4", motor_count, 32'd4);
    step_in = 1'b1;
    tick();
    check("zero state", state, 3);
    check("zero en", en_out, 0);
    step_in = 1'b0;
    tick();
    check("run state", state, 4);
    check("run count", motor_count, 32'd0);
    check("run homed", homed, 1);
    check("run take", take_ctrl, 0);

    // Saturation in RUN
    cmd_en = 1'b1; cmd_dir = 1'b0;
    tick();
    check("run en", en_out, 1);
    step(3);
    check("run sat0", motor_count, 32'd0);
    cmd_dir = 1'b1;
    tick();
    check("run dir away", mtr_dir, 1);
    step(3);
    check("run count3", motor_count, 32'd3);
    force dut.motor_count = 32'hFFFF_FFFE;
    step(1);
    release dut.motor_count;
    step(3);
    check("run satmax", motor_count, 32'hFFFF_FFFF);
    cmd_dir = 1'b0;
    tick();
    step(1);
    check("run dec", motor_count, 32'hFFFF_FFFE);

    // sup_error in RUN leaves state and homed alone
    sup_error = 1'b1;
    tick(2);
    check("run sup state", state, 4);
    check("run sup homed", homed, 1);
    sup_error = 1'b0;

    // Seek timeout
    pulse_start();
    check("reseek state", state, 1);
    check("reseek homed", homed, 0);
    step(49);
    check("seek 49", state, 1);
    step(1);
    check("timeout state", state, 5);
    check("timeout fault", home_fault, 1);
    check("timeout en", en_out, 0);
    check("timeout count", motor_count, 32'hFFFF_FFCC);
    step(1);
    check("fault nocount", motor_count, 32'hFFFF_FFCC);
    pulse_start();
    check("fault exit", state, 1);
    check("fault clr", home_fault, 0);

    // sup_error coincident with the final backoff step
    sensor_raw = 1'b1;
    for (int i = 0; i < 20 && state != 3'd2; i++) tick();
    check("wait backoff", state, 2);
    sensor_raw = 1'b0;
    tick(8);
    step(4);
    step_in = 1'b1; sup_error = 1'b1;
    tick();
    check("sup backoff state", state, 5);
    step_in = 1'b0; sup_error = 1'b0;
    tick();
    check("sup fault hold", state, 5);
    check("sup homed", homed, 0);
    check("sup fault", home_fault, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/home_pos_ctrl.md
Name: home_pos_ctrl

Overview:
- Sits directly upstream of the end-stop supervisor.
- Tracks rail position from step pulses and produces the 32-bit motor_count the supervisor compares against max_count.
- Runs the homing sequence: seek the sensor, back off, zero the count. Drives take_ctrl, mtr_dir and en_in toward the supervisor.
- Sensor input is synchronised and debounced here.

Parameters:
- DEBOUNCE_CYC, 1000, clk cycles the synchronised sensor must be stable before its filtered value changes.
- BACKOFF_STEPS, 200, steps moved away from the sensor after first contact.
- SEEK_MAX_STEPS, 2000000, step limit in SEEK before home_fault.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_home  in  1  single-cycle pulse; starts homing from IDLE, RUN or FAULT
- homing_dir  in  1  mtr_dir value that moves toward the sensor
- sensor_raw  in  1  asynchronous end-stop sensor, active-high
- step_in  in  1  step pulse train from the motion generator; one count per rising edge
- cmd_dir  in  1  motion direction in RUN
- cmd_en  in  1  motion enable in RUN
- sup_error  in  1  error output of the supervisor
- motor_count  out  32  current position in steps; 0 = home
- mtr_dir  out  1  direction to supervisor and driver
- en_out  out  1  to supervisor en_in
- take_ctrl  out  1  high while homing owns the axis
- sensor_f  out  1  debounced sensor, also routed to the supervisor sensor input
- homed  out  1  position valid
- home_fault  out  1  homing failed
- state  out  3  FSM state code, debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE; motor_count=0; mtr_dir=homing_dir; all other outputs 0; synchroniser flops and debounce counter cleared.
- Sensor path:
  - 2-flop synchroniser, then debounce counter.
  - sensor_f changes only after DEBOUNCE_CYC consecutive cycles of the new value; any glitch restarts the count.
  - Latency from sensor_raw to sensor_f = 2 + DEBOUNCE_CYC cycles.
- Step detect:
  - step_in is registered; a rising edge gives a one-cycle step_evt.
  - step_in is treated as synchronous to clk.
- Counting, on step_evt:
  - toward = (mtr_dir == homing_dir).
  - toward: motor_count decrements, saturating at 0.
  - away: motor_count increments, saturating at 32'hFFFFFFFF.
  - No wrap in either direction. Counting is active in every state except IDLE and FAULT.
- FSM states: IDLE=0, SEEK=1, BACKOFF=2, ZERO=3, RUN=4, FAULT=5.
- IDLE: en_out=0, take_ctrl=0. start_home -> SEEK.
- SEEK:
  - take_ctrl=1, mtr_dir=homing_dir, en_out=1; step counter cleared on entry.
  - sensor_f=1 -> BACKOFF.
  - SEEK_MAX_STEPS steps counted -> FAULT.
  - If sensor_f is already 1 on entry, go to BACKOFF next cycle.
- BACKOFF:
  - take_ctrl=1, mtr_dir=~homing_dir, en_out=1.
  - After BACKOFF_STEPS steps with sensor_f=0 -> ZERO.
  - If sensor_f is still 1 after BACKOFF_STEPS steps -> FAULT.
- ZERO:
  - One cycle, en_out=0.
  - motor_count<=0 and homed<=1 -> RUN.
- RUN:
  - take_ctrl=0, en_out=cmd_en, mtr_dir=cmd_dir.
  - start_home -> SEEK, clearing homed.
- FAULT:
  - en_out=0, take_ctrl=0, home_fault=1, homed=0.
  - Exit only via start_home -> SEEK, which clears home_fault.
- sup_error:
  - sup_error=1 in SEEK or BACKOFF -> FAULT the next cycle.
  - sup_error=1 in RUN: homed stays 1 (the supervisor gates the enable); the state does not change.
- Simultaneous events:
  - sup_error takes priority over sensor_f and over step-limit transitions.
  - start_home in SEEK or BACKOFF is ignored.
  - A step_evt in the same cycle as the ZERO clear is discarded; the count is 0 afterwards.
- Outputs en_out, mtr_dir, take_ctrl and state are registered: 1-cycle latency from the state transition.
- Reset mid-homing returns to IDLE with homed=0; no automatic restart.

Decomposition:
- Shared package holds:
  - FSM state codes (3-bit localparams), also used by the debug readback.
  - COUNT_W=32.
- One sub-module, sensor_debounce: synchroniser plus counter, with parameter DEBOUNCE_CYC and ports clk, rst_n, din, dout.

Test Plan:
- Reset: hold rst_n=0 with step_in toggling -> motor_count=0, en_out=0, state=0, homed=0. Release -> still IDLE.
- Normal homing, DEBOUNCE_CYC=4, BACKOFF_STEPS=5: start_home, 10 steps, assert sensor_raw. Expected:
  - sensor_f rises 6 cycles after sensor_raw.
  - BACKOFF moves mtr_dir=~homing_dir; drop sensor_raw after 2 steps.
  - After 5 away steps, ZERO then RUN with motor_count=0, homed=1.
- Glitch rejection: 3-cycle sensor_raw pulses during SEEK -> sensor_f stays 0 and the FSM stays in SEEK.
- Seek timeout, SEEK_MAX_STEPS=50: no sensor -> FAULT after the 50th step_evt; home_fault=1, en_out=0. A following start_home -> SEEK.
- Saturation in RUN, cmd_en=1:
  - cmd_dir toward with count 0, 3 steps -> count stays 0.
  - Force count to 32'hFFFFFFFE, 3 away steps -> 32'hFFFFFFFF.
- Supervisor error: sup_error=1 in BACKOFF coincident with the final step -> FAULT (not ZERO), homed=0.
